load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface: accepts load/store requests from the MEM pipeline stage and drives the word-addressed, 1024-word data memory. The memory has a combinational read port and a synchronous whole-word write port. This block converts byte addresses to word indices and performs byte and halfword accesses. Sub-word stores use a single-cycle read-modify-write. Every request returns exactly one response, with fixed latency, including an error flag for misaligned or out-of-range addresses.

## Interface
- MEM_WORDS, 1024: data memory depth in 32-bit words; the valid byte range is 0 .. 4*MEM_WORDS-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and treated as misaligned.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0) sub-word data.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid: misaligned or out-of-range access.
- mem_address  out  32  word index = req_addr[31:2], held in a register.
- mem_write_enable  out  1  memory write strobe.
- mem_write_data  out  32  full word written to memory.
- mem_read_data  in  32  combinational read of mem_address.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. The reset state is IDLE with req_ready = 0.
- The block does not accept a request on the first edge after rst deasserts. req_ready becomes 1 after that edge.
- IDLE: req_ready = 1. On acceptance, the block captures write, size, signed, addr and wdata, then moves to ACCESS.
- ACCESS: req_ready = 0. The block drives mem_address from the captured address and moves to RESP on the next edge.
- RESP: resp_valid = 1 for exactly one cycle. On the next edge the block returns to IDLE and req_ready returns to 1.
- Error check happens at capture:
  - Error if the halfword is not 2-aligned, the word is not 4-aligned, or req_size = 3.
  - Error if req_addr >= 4*MEM_WORDS.
  - An errored request still passes through ACCESS, with mem_write_enable = 0 and no memory change. RESP then carries resp_error = 1 and resp_rdata = 0.
- Byte order is little-endian: byte lane k = addr[1:0] occupies bits [8k+7:8k]; halfword lane addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
- Load: in ACCESS the block selects the lane from mem_read_data and extends it per req_signed into a response register. The register is visible in RESP.
- Store:
  - mem_write_enable = 1 only during ACCESS of a non-errored store.
  - Word store: mem_write_data = wdata.
  - Byte/halfword store: mem_write_data = mem_read_data with only the target lane replaced by wdata[7:0] or wdata[15:0]. The other lanes are preserved bit-exact.
- mem_write_enable and mem_write_data are combinational from state and captured registers plus mem_read_data. They must be 0 outside ACCESS.
- resp_rdata and resp_error are 0 whenever resp_valid = 0.
- Reset mid-operation: rst immediately forces IDLE. It drops any pending response and deasserts mem_write_enable and resp_valid asynchronously. A write whose edge coincides with rst assertion is lost.

## Timing
- Request accepted at edge N:
  - ACCESS occupies cycle N..N+1; the memory write commits at edge N+1.
  - resp_valid is high in cycle N+1..N+2.
  - req_ready is 1 again after edge N+2.
- Fixed latency is 2 edges from acceptance to resp_valid. Maximum throughput is one request per 3 cycles.
- There is no back-pressure on the response; the consumer must take resp_valid when it pulses.
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_error 0, mem_address 0, mem_write_enable 0, mem_write_data 0.
- req_valid while req_ready = 0 is ignored and is not queued.

## Test plan
- Word round trip: store word 0xDEADBEEF at addr 0x80, then load word at 0x80 -> memory word 32 = 0xDEADBEEF; resp_rdata = 0xDEADBEEF, resp_error 0, resp_valid exactly 2 edges after each acceptance.
- Byte merge: word 32 = 0x11223344; store byte 0xAA at 0x82 -> word 32 = 0x11AA3344. Signed byte load at 0x82 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword: store 0x8001 at 0x86 -> word 33 upper half = 0x8001, lower half unchanged. Signed load -> 0xFFFF8001; unsigned -> 0x00008001.
- Errors: word store at 0x82, halfword load at 0x81, word load at 0x1000 -> each gives resp_error 1 and resp_rdata 0; mem_write_enable never high and memory unchanged.
- Handshake: hold req_valid high continuously with back-to-back requests -> exactly one acceptance every 3 cycles, and req_ready is low in ACCESS and RESP.
- Reset: assert rst during ACCESS of a store -> no resp_valid and outputs at reset values. First edge after release does not accept; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-addressed data-memory interface.
// Turns byte-addressed load/store requests from the MEM stage into whole-word
// memory accesses. Byte and halfword stores are read-modify-write within a
// single ACCESS cycle. Each accepted request yields exactly one response,
// two edges after acceptance.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_write_i              1 = store, 0 = load
//   req_size_i               0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed_i             sign-extend sub-word loads
//   req_addr_i, req_wdata_i  byte address, right-justified store data
//   resp_valid_o             one-cycle response pulse
//   resp_rdata_o             extended load data (0 for stores/errors)
//   resp_error_o             misaligned or out-of-range access
//   mem_address_o            registered word index
//   mem_write_enable_o       write strobe (ACCESS of a good store only)
//   mem_write_data_o         merged word to write
//   mem_read_data_i          combinational read of mem_address_o
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_error_o,
   output logic [31:0] mem_address_o,
   output logic        mem_write_enable_o,
   output logic [31:0] mem_write_data_o,
   input  logic [31:0] mem_read_data_i
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_ACCESS = 2'd1;
   localparam logic [1:0]  S_RESP   = 2'd2;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   logic [1:0]  state_q, state_d;
   logic        ready_q, ready_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] maddr_q, maddr_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept = req_valid_i && ready_q;

   // Misalignment, illegal size and out-of-range checks on the incoming request
   always_comb begin
      req_err = 1'b0;
      unique case (req_size_i)
         2'd0:    req_err = 1'b0;
         2'd1:    req_err = req_addr_i[0];
         2'd2:    req_err = (req_addr_i[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if (req_addr_i >= ADDR_LIMIT) req_err = 1'b1;
   end

   // Lane selection and extension of the read word for loads
   always_comb begin
      byte_sel = mem_read_data_i[{lane_q, 3'b000} +: 8];
      half_sel = mem_read_data_i[{lane_q[1], 4'b0000} +: 16];
      unique case (size_q)
         2'd0:    load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'd1:    load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_ext = mem_read_data_i;
      endcase
   end

   // Store word: replace only the target lane of the current memory word
   always_comb begin
      merged = mem_read_data_i;
      unique case (size_q)
         2'd0:    merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
         2'd1:    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      ready_d  = 1'b0;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      lane_d   = lane_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      maddr_d  = maddr_q;
      rvalid_d = 1'b0;
      rdata_d  = 32'h0;
      rerr_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               state_d  = S_ACCESS;
               ready_d  = 1'b0;
               write_d  = req_write_i;
               size_d   = req_size_i;
               signed_d = req_signed_i;
               lane_d   = req_addr_i[1:0];
               wdata_d  = req_wdata_i;
               err_d    = req_err;
               maddr_d  = {2'b00, req_addr_i[31:2]};
            end
         end
         S_ACCESS: begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerr_d   = err_q;
            rdata_d  = (!err_q && !write_q) ? load_ext : 32'h0;
         end
         S_RESP: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset holds ready low so the first edge after release never accepts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b0;
         write_q  <= 1'b0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         lane_q   <= 2'd0;
         wdata_q  <= 32'h0;
         err_q    <= 1'b0;
         maddr_q  <= 32'h0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         lane_q   <= lane_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         maddr_q  <= maddr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

   assign req_ready_o        = ready_q;
   assign resp_valid_o       = rvalid_q;
   assign resp_rdata_o       = rdata_q;
   assign resp_error_o       = rerr_q;
   assign mem_address_o      = maddr_q;
   // Write strobe follows the state register directly so reset removes it at once
   assign mem_write_enable_o = (state_q == S_ACCESS) && write_q && !err_q;
   assign mem_write_data_o   = mem_write_enable_o ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1024-word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_clr = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready_o;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_error_o;
   logic [31:0] mem_address_o;
   logic        mem_write_enable_o;
   logic [31:0] mem_write_data_o;
   logic [31:0] mem_read_data;

   logic [31:0] mem [1024];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o),
      .req_write_i(req_write), .req_size_i(req_size), .req_signed_i(req_signed),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_error_o(resp_error_o),
      .mem_address_o(mem_address_o), .mem_write_enable_o(mem_write_enable_o),
      .mem_write_data_o(mem_write_data_o), .mem_read_data_i(mem_read_data)
   );

   assign mem_read_data = (mem_address_o < 32'd1024) ? mem[mem_address_o[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (mem_write_enable_o && (mem_address_o < 32'd1024)) begin
         mem[mem_address_o[9:0]] <= mem_write_data_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request through the full handshake, checking every cycle of it
   task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
      int n;
      @(negedge clk);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_acc_we"}, 32'(mem_write_enable_o), 32'(w && !exp_err));
      chk({tag, "_acc_ready"}, 32'(req_ready_o), 32'd0);
      chk({tag, "_acc_rv"}, 32'(resp_valid_o), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rv"}, 32'(resp_valid_o), 32'd1);
      chk({tag, "_err"}, 32'(resp_error_o), 32'(exp_err));
      chk({tag, "_rdata"}, resp_rdata_o, exp_rd);
      chk({tag, "_resp_ready"}, 32'(req_ready_o), 32'd0);
      chk({tag, "_resp_we"}, 32'(mem_write_enable_o), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_post_rv"}, 32'(resp_valid_o), 32'd0);
      chk({tag, "_post_rdata"}, resp_rdata_o, 32'h0);
      chk({tag, "_post_ready"}, 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, rv, last_acc;
      logic rdy;

      // Reset values
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rv", 32'(resp_valid_o), 32'd0);
      chk("rst_rdata", resp_rdata_o, 32'h0);
      chk("rst_err", 32'(resp_error_o), 32'd0);
      chk("rst_maddr", mem_address_o, 32'h0);
      chk("rst_we", 32'(mem_write_enable_o), 32'd0);
      chk("rst_wdata", mem_write_data_o, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; mem_clr = 1'b0;
      chk("rel_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
      chk("rel_ready_after", 32'(req_ready_o), 32'd1);

      // Word round trip
      issue("sw80", 1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0, 32'h0);
      chk("mem32_a", mem[32], 32'hDEADBEEF);
      issue("lw80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b0, 32'hDEADBEEF);

      // Byte merge
      issue("sw80b", 1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344, 1'b0, 32'h0);
      issue("sb82", 1'b1, 2'd0, 1'b0, 32'h82, 32'hFFFFFFAA, 1'b0, 32'h0);
      chk("mem32_b", mem[32], 32'h11AA3344);
      issue("lb82", 1'b0, 2'd0, 1'b1, 32'h82, 32'h0, 1'b0, 32'hFFFFFFAA);
      issue("lbu82", 1'b0, 2'd0, 1'b0, 32'h82, 32'h0, 1'b0, 32'h000000AA);
      issue("lbu80", 1'b0, 2'd0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h00000044);

      // Halfword
      issue("sw84", 1'b1, 2'd2, 1'b0, 32'h84, 32'h55667788, 1'b0, 32'h0);
      issue("sh86", 1'b1, 2'd1, 1'b0, 32'h86, 32'h12348001, 1'b0, 32'h0);
      chk("mem33", mem[33], 32'h80017788);
      issue("lh86", 1'b0, 2'd1, 1'b1, 32'h86, 32'h0, 1'b0, 32'hFFFF8001);
      issue("lhu86", 1'b0, 2'd1, 1'b0, 32'h86, 32'h0, 1'b0, 32'h00008001);
      issue("lh84", 1'b0, 2'd1, 1'b1, 32'h84, 32'h0, 1'b0, 32'h00007788);

      // Errors and boundaries
      issue("sw82_err", 1'b1, 2'd2, 1'b0, 32'h82, 32'hCAFEBABE, 1'b1, 32'h0);
      chk("mem32_err", mem[32], 32'h11AA3344);
      issue("sh87_err", 1'b1, 2'd1, 1'b0, 32'h87, 32'hCAFEBABE, 1'b1, 32'h0);
      chk("mem33_err", mem[33], 32'h80017788);
      issue("lh81_err", 1'b0, 2'd1, 1'b1, 32'h81, 32'h0, 1'b1, 32'h0);
      issue("lw1000_err", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
      issue("sz3_err", 1'b0, 2'd3, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
      issue("sbFFF", 1'b1, 2'd0, 1'b0, 32'hFFF, 32'h12345678, 1'b0, 32'h0);
      chk("mem1023", mem[1023], 32'h78000000);
      issue("lbFFF", 1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, 1'b0, 32'h00000078);

      // Back-to-back loads with req_valid held high
      @(negedge clk);
      req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h80;
      req_valid = 1'b1;
      acc = 0; rv = 0; last_acc = -3;
      for (int i = 0; i < 12; i++) begin
         rdy = req_ready_o;
         @(posedge clk); #1;
         if (rdy) begin
            chk("b2b_spacing", 32'(i - last_acc), 32'd3);
            chk("b2b_acc_ready", 32'(req_ready_o), 32'd0);
            last_acc = i;
            acc++;
         end
         if (resp_valid_o) begin
            rv++;
            chk("b2b_resp_ready", 32'(req_ready_o), 32'd0);
            chk("b2b_rdata", resp_rdata_o, 32'h11AA3344);
         end
      end
      req_valid = 1'b0;
      chk("b2b_acc_count", 32'(acc), 32'd4);
      chk("b2b_resp_count", 32'(rv), 32'd4);
      repeat (2) @(posedge clk);

      // Reset during ACCESS of a store
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'hA5A5A5A5;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mr_acc_we", 32'(mem_write_enable_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mr_we", 32'(mem_write_enable_o), 32'd0);
      chk("mr_wdata", mem_write_data_o, 32'h0);
      chk("mr_rv", 32'(resp_valid_o), 32'd0);
      chk("mr_ready", 32'(req_ready_o), 32'd0);
      chk("mr_maddr", mem_address_o, 32'h0);
      chk("mr_err", 32'(resp_error_o), 32'd0);
      @(posedge clk); #1;
      chk("mr_rv_edge", 32'(resp_valid_o), 32'd0);
      chk("mr_mem64", mem[64], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
      req_valid = 1'b1;
      chk("mr_rel_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
      chk("mr_first_edge_ready", 32'(req_ready_o), 32'd1);
      chk("mr_first_edge_we", 32'(mem_write_enable_o), 32'd0);
      chk("mr_first_edge_rv", 32'(resp_valid_o), 32'd0);
      issue("mr_lw100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
      issue("mr_sw100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h600DF00D, 1'b0, 32'h0);
      chk("mr_mem64_after", mem[64], 32'h600DF00D);
      issue("mr_lw100b", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'h600DF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
